// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like slave between fetch (m0) and load/store (m1) masters
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   m0_*, m1_*        SRAM-like masters (req/wr/size/addr/wdata in, rdata/addr_ok/data_ok out)
//   s_*               SRAM-like slave channel
//   outstanding       accepted-but-unreturned transaction count
//   err_spurious      sticky flag: slave returned data with nothing outstanding
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic [3:0]  outstanding,
    output logic        err_spurious
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    state_t r_state;
    logic [PW-1:0] r_wp, r_rp;
    logic [3:0] r_cnt, r_starve;
    logic [MAX_OUTSTANDING-1:0] r_own;
    logic r_err;
    logic w_full, w_pri1, w_g0, w_g1, w_acc, w_pop, w_head;
    // m1 wins unless m0 has waited through STARVE_LIMIT m1 grants
    assign w_full = r_cnt == 4'(MAX_OUTSTANDING);
    assign w_pri1 = m1_req && !(m0_req && r_starve == 4'(STARVE_LIMIT));
    // a locked master keeps the channel; reset silences every grant at once
    assign w_g1 = !reset && !w_full && (r_state == LOCK1 || (r_state == IDLE && w_pri1));
    assign w_g0 = !reset && !w_full && (r_state == LOCK0 || (r_state == IDLE && !w_pri1 && m0_req));
    assign s_req = (w_g0 & m0_req) | (w_g1 & m1_req);
    assign s_wr = w_g0 ? m0_wr : w_g1 ? m1_wr : 1'b0;
    assign s_size = w_g0 ? m0_size : w_g1 ? m1_size : 2'd0;
    assign s_addr = w_g0 ? m0_addr : w_g1 ? m1_addr : 32'd0;
    assign s_wdata = w_g0 ? m0_wdata : w_g1 ? m1_wdata : 32'd0;
    assign w_acc = s_req & s_addr_ok;
    assign m0_addr_ok = w_acc & w_g0;
    assign m1_addr_ok = w_acc & w_g1;
    assign w_pop = !reset && s_data_ok && r_cnt != 4'd0;
    assign w_head = r_own[r_rp];
    assign m0_data_ok = w_pop & !w_head;
    assign m1_data_ok = w_pop & w_head;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign outstanding = r_cnt;
    assign err_spurious = r_err;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            r_starve <= '0;
            r_own <= '0;
            r_err <= 1'b0;
        end else begin
            // an unaccepted request locks its master; dropping req or acceptance unlocks
            r_state <= (s_req && !s_addr_ok) ? (w_g1 ? LOCK1 : LOCK0) : IDLE;
            if (w_acc) begin
                r_own[r_wp] <= w_g1;
                r_wp <= (r_wp == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= (r_rp == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + 4'(w_acc) - 4'(w_pop);
            if (!m0_req || m0_addr_ok)
                r_starve <= '0;
            else if (m1_addr_ok && r_starve != 4'(STARVE_LIMIT))
                r_starve <= r_starve + 4'd1;
            if (s_data_ok && r_cnt == 4'd0)
                r_err <= 1'b1;
        end
    end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like slave channel (the instruction/data-facing side of the AXI bridge) between two SRAM-like masters: m0 (instruction fetch) and m1 (load/store).
- Grants address phases with data-priority plus an anti-starvation guarantee for fetch.
- Tracks the owner of every outstanding transaction in an in-order FIFO, so each data_ok and rdata is returned to the correct master.

Parameters:
- MAX_OUTSTANDING, 4, owner-FIFO depth (2..8); limits accepted-but-unreturned transactions.
- STARVE_LIMIT, 3, consecutive m1 grants allowed while m0 waits before m0 is forced through (1..15).

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  fetch request
- m0_wr  in  1  fetch write flag (normally 0; passed through)
- m0_size  in  2  transfer size
- m0_addr  in  32  address
- m0_wdata  in  32  write data
- m0_rdata  out  32  read data
- m0_addr_ok  out  1  address accepted
- m0_data_ok  out  1  data returned
- m1_req / m1_wr / m1_size / m1_addr / m1_wdata  in  1/1/2/32/32  load/store request, same meaning as m0
- m1_rdata / m1_addr_ok / m1_data_ok  out  32/1/1  same meaning as m0
- s_req / s_wr / s_size / s_addr / s_wdata  out  1/1/2/32/32  to slave
- s_rdata  in  32  from slave
- s_addr_ok  in  1  slave accepted address
- s_data_ok  in  1  slave returned data
- outstanding  out  4  current FIFO occupancy
- err_spurious  out  1  sticky: s_data_ok seen with empty FIFO

Behaviour:
- FSM states:
  - IDLE: no locked request.
  - LOCK0 / LOCK1: s_req was asserted for m0/m1 and not yet accepted.
- Grant in IDLE (combinational):
  - If FIFO full, no grant.
  - Else if m1_req, and not (m0_req and starve_cnt==STARVE_LIMIT), grant m1.
  - Else if m0_req, grant m0.
- Lock:
  - If granted and s_addr_ok==0, next state is LOCKx.
  - In LOCKx, s_* is driven from master x only, until s_addr_ok. Then return to IDLE. A new request is not issued in the same cycle.
  - A lower/higher-priority request never preempts a locked one.
  - If the locked master drops req before addr_ok, return to IDLE with no push; s_req follows the master's req.
- Slave-side outputs:
  - s_req = granted master's req, gated by FIFO not full.
  - s_wr/s_size/s_addr/s_wdata are muxed from the granted master; 0 when no grant.
- Acceptance:
  - mx_addr_ok = s_addr_ok & s_req & (grant==x).
  - On acceptance, push x into the owner FIFO.
  - Zero added latency: acceptance is combinational in the same cycle.
- Starvation counter (starve_cnt):
  - Increments on each m1 acceptance while m0_req=1.
  - Clears on m0 acceptance or when m0_req=0.
  - Saturates at STARVE_LIMIT.
- Return:
  - s_data_ok with FIFO non-empty pops the head owner h.
  - mh_data_ok=1 the same cycle; the other master's data_ok=0.
  - Both m0_rdata and m1_rdata = s_rdata; qualified only by data_ok.
- Simultaneous push and pop:
  - Allowed in the same cycle; occupancy is unchanged.
  - Allowed when full: the pop frees a slot only for the next cycle; no grant while full.
- Empty FIFO with s_data_ok: no master data_ok; err_spurious sets and holds until reset.
- FIFO: circular buffer; read/write pointers wrap modulo MAX_OUTSTANDING; occupancy counter 0..MAX_OUTSTANDING.
- Reset (asynchronous, any time, including mid-transaction):
  - State to IDLE; FIFO pointers, occupancy, starve_cnt and err_spurious to 0.
  - All outputs 0: s_req, addr_ok/data_ok, outstanding.
  - In-flight transactions are discarded; the slave must be reset together with this block.

Test Plan:
- Single fetch: m0_req=1 addr 0xBFC00000, s_addr_ok same cycle → m0_addr_ok=1, outstanding=1. Slave later returns s_data_ok with rdata 0x3C08BFAF → m0_data_ok=1, m0_rdata=0x3C08BFAF, m1_data_ok=0, outstanding=0.
- Contention: m0_req and m1_req both held, s_addr_ok always 1, STARVE_LIMIT=3 → grant order m1,m1,m1,m0,m1,m1,m1,m0. The data_ok sequence follows the same order.
- Lock: m0 granted, s_addr_ok=0 for 3 cycles, m1_req rises in cycle 2 → s_addr stays m0_addr throughout. The 4th cycle with s_addr_ok → m0_addr_ok; m1 is granted next cycle.
- Full: MAX_OUTSTANDING=4, accept 4 requests with no data_ok → s_req=0, outstanding=4. Then one s_data_ok → outstanding=3 next cycle and a grant resumes. Also check push+pop in the same cycle keeps outstanding constant.
- Spurious return: s_data_ok=1 with outstanding=0 → no master data_ok; err_spurious=1, held until reset.
- Reset mid-op: assert reset with outstanding=2 and state LOCK1 → all outputs 0 immediately. After release, the next fetch is returned to m0 correctly.
